fir_decim_quant: RTL
====================

# fir_decim_quant

Output stage placed directly downstream of the direct-form `fir` filter. It takes the 20-bit signed MAC output and keeps one of every DECIM valid samples. Each kept sample is rounded and right-shifted by SHIFT, then saturated to OUT_WL bits. Results are buffered in a small FIFO and presented on a valid/ready stream to the next consumer, with sticky saturation and overflow flags.

## Interface
- IN_WL, 20, width of signed input (matches FIR macWL)
- OUT_WL, 16, width of signed output
- SHIFT, 4, arithmetic right shift applied with rounding (SHIFT ≥ 1)
- DECIM, 2, decimation factor (≥ 1; 1 = pass every sample)
- FIFO_DEPTH, 4, output buffer depth (power of 2, ≥ 2)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  IN_WL  signed FIR output sample
- in_valid  in  1  data_in valid this cycle
- out_data  out  OUT_WL  signed quantized sample at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- clr  in  1  synchronous clear of sticky flags only
- sat_flag  out  1  sticky: a kept sample saturated
- ovf_flag  out  1  sticky: a sample was dropped because the FIFO was full

## Operation
- Phase counter 0..DECIM-1 advances (wraps) on every edge with in_valid=1. When in_valid=0 it holds.
- A sample is kept when in_valid=1 and phase==0, so the first valid sample after reset is always kept.
- Quantization of a kept sample x:
  - r = (x + 2^(SHIFT-1)) >>> SHIFT, computed at IN_WL+1 bits with no wrap.
  - If r > 2^(OUT_WL-1)-1, output 2^(OUT_WL-1)-1 and set sat_flag.
  - If r < -2^(OUT_WL-1), output -2^(OUT_WL-1) and set sat_flag.
- Pipeline: a kept sample is registered into the quant stage (q_data, q_valid). One edge later it is written into the FIFO.
- FIFO write occurs when q_valid=1 and (not full, or a pop occurs on the same edge).
  - Otherwise the q sample is discarded and ovf_flag is set.
  - The quant stage never stalls upstream; the FIR stream has no backpressure.
- FIFO pop occurs when out_valid=1 and out_ready=1.
  - A simultaneous push and pop keeps the count unchanged, including when full or when holding 1 entry.
  - Pop on empty is ignored.
- out_data is the show-ahead head entry. It is 0 when the FIFO is empty.
- clr=1 clears sat_flag/ovf_flag on that edge. A flag-setting event on the same edge wins (flag ends at 1).
- Reset (at any time, including mid-stream):
  - phase=0; q_valid=0, q_data=0; FIFO empty with pointers at 0.
  - out_valid=0, out_data=0, sat_flag=0, ovf_flag=0.
  - Buffered data is lost.

## Timing
- Kept sample sampled at edge E:
  - quant register loaded at E;
  - FIFO written at E+1;
  - out_valid=1 after E+1 (latency 2 edges when the FIFO has room).
- With out_ready held 1 and DECIM=1, throughput is one sample per cycle and the FIFO occupancy stays ≤ 1.
- Sticky flags update on the same edge as the causing event: sat_flag at E, ovf_flag at E+1.
- out_valid deasserts on the edge that pops the last entry unless a push lands on the same edge.

## Test plan
- Rounding, default params, DECIM=1, out_ready=1:
  - inputs 100, −100, 8, −8, 7 → outputs 6, −6, 1, 0, 0.
  - sat_flag=0 throughout.
- Saturation:
  - input 524287 → 32767 and sat_flag=1.
  - input −524288 → −32768 with no further flag change.
  - pulse clr → sat_flag=0.
- Decimation DECIM=2:
  - inputs 16, 32, 48, 64 back-to-back → outputs 1, 3 only.
  - inserting in_valid=0 gaps between the samples yields the same outputs.
- Latency and reset:
  - apply a sample two edges after rst_n rises → out_valid rises exactly 2 edges later.
  - assert rst_n=0 asynchronously mid-stream → out_valid, out_data and the flags go to 0 immediately.
- Overflow, DECIM=1, out_ready=0:
  - inputs 16, 32, 48, 64, 80, 96 → FIFO holds 4 entries, ovf_flag=1.
  - raise out_ready → drains 1, 2, 3, 4 in order, then out_valid=0.
- Full push+pop: with the FIFO full, pop and push on the same edge → count stays 4, no overflow, order preserved.

Source files
------------

// File: rtl/fir_decim_quant.sv
// Output stage behind the direct-form FIR: decimates, rounds/shifts, saturates and
// buffers samples in a small show-ahead FIFO with sticky saturation/overflow flags.
module fir_decim_quant #(
  parameter int IN_WL      = 20,
  parameter int OUT_WL     = 16,
  parameter int SHIFT      = 4,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_WL-1:0]  data_in,
  input  logic              in_valid,
  output logic [OUT_WL-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr,
  output logic              sat_flag,
  output logic              ovf_flag
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [IN_WL:0] RND_C = {{IN_WL{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_WL:0] OMAX_C =
    {{(IN_WL - OUT_WL + 1){1'b0}}, 1'b0, {(OUT_WL - 1){1'b1}}};
  localparam logic signed [IN_WL:0] OMIN_C =
    {{(IN_WL - OUT_WL + 1){1'b1}}, 1'b1, {(OUT_WL - 1){1'b0}}};

  // Returns {saturated, value}; the extra bit keeps the rounding add from wrapping.
  function automatic logic [OUT_WL:0] quantize(input logic [IN_WL-1:0] x);
    logic signed [IN_WL:0] sum;
    logic signed [IN_WL:0] r;
    sum = {x[IN_WL-1], x} + RND_C;
    r   = sum >>> SHIFT;
    if (r > OMAX_C) begin
      quantize = {1'b1, OMAX_C[OUT_WL-1:0]};
    end else if (r < OMIN_C) begin
      quantize = {1'b1, OMIN_C[OUT_WL-1:0]};
    end else begin
      quantize = {1'b0, r[OUT_WL-1:0]};
    end
  endfunction

  logic [PW-1:0]     phase_r;
  logic              q_valid_r;
  logic [OUT_WL-1:0] q_data_r;
  logic [OUT_WL-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [CW-1:0]     cnt_r;
  logic [OUT_WL-1:0] out_data_r;
  logic              out_valid_r;
  logic              sat_flag_r;
  logic              ovf_flag_r;

  logic              keep_s;
  logic [OUT_WL:0]   qres_s;
  logic              pop_s;
  logic              push_s;
  logic              ovf_evt_s;
  logic [CW-1:0]     cnt_nxt_s;
  logic [AW-1:0]     rd_ptr_nxt_s;
  logic [OUT_WL-1:0] head_nxt_s;

  // Keep/quantize decisions and next FIFO state; head is precomputed so out_data is a register.
  always_comb begin
    keep_s       = in_valid && (phase_r == {PW{1'b0}});
    qres_s       = quantize(data_in);
    pop_s        = out_valid_r && out_ready;
    push_s       = q_valid_r && ((cnt_r != CW'(FIFO_DEPTH)) || pop_s);
    ovf_evt_s    = q_valid_r && !push_s;
    cnt_nxt_s    = cnt_r + CW'(push_s) - CW'(pop_s);
    rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
    if ((cnt_r - CW'(pop_s)) == {CW{1'b0}}) begin
      if (push_s) begin
        head_nxt_s = q_data_r;
      end else begin
        head_nxt_s = {OUT_WL{1'b0}};
      end
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Decimation phase, advancing only on valid input samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {PW{1'b0}};
    end else if (in_valid) begin
      if (phase_r == PW'(DECIM - 1)) begin
        phase_r <= {PW{1'b0}};
      end else begin
        phase_r <= phase_r + PW'(1);
      end
    end else begin
      phase_r <= phase_r;
    end
  end

  // Quant stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid_r <= 1'b0;
      q_data_r  <= {OUT_WL{1'b0}};
    end else begin
      q_valid_r <= keep_s;
      if (keep_s) begin
        q_data_r <= qres_s[OUT_WL-1:0];
      end else begin
        q_data_r <= q_data_r;
      end
    end
  end

  // Sticky flags: a setting event on the same edge as clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_r <= 1'b0;
      ovf_flag_r <= 1'b0;
    end else begin
      sat_flag_r <= (keep_s && qres_s[OUT_WL]) || (sat_flag_r && !clr);
      ovf_flag_r <= ovf_evt_s || (ovf_flag_r && !clr);
    end
  end

  // Output FIFO storage, pointers and registered head/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {OUT_WL{1'b0}};
      end
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_data_r  <= {OUT_WL{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= q_data_r;
      end else begin
        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
      wr_ptr_r    <= wr_ptr_r + AW'(push_s);
      rd_ptr_r    <= rd_ptr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      out_data_r  <= head_nxt_s;
      out_valid_r <= (cnt_nxt_s != {CW{1'b0}});
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign sat_flag  = sat_flag_r;
  assign ovf_flag  = ovf_flag_r;

endmodule
